// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: multiply/divide issue sequencer owning HI/LO (MD_DIV0_FAST_EN skips divide-by-zero)
module md_issue_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_E,
    input  logic [3:0]  MDOp,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    input  logic        md_in_D,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    output logic        core_signed,
    output logic        core_div,
    input  logic [31:0] core_hi,
    input  logic [31:0] core_lo,
    output logic        start,
    output logic        busy,
    output logic        stall_D,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rdata
);
    localparam int MAX_CYC = DIV_CYC > MULT_CYC ? DIV_CYC : MULT_CYC;
    localparam int CW = $clog2(MAX_CYC);
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYC - 1);
    localparam logic [CW-1:0] DIV_N = CW'(DIV_CYC - 1);
    typedef enum logic [1:0] {IDLE, ISSUE, RUN} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic is_md, is_div, div0_skip;
    assign is_md = req_E && MDOp >= 4'd1 && MDOp <= 4'd4;
    assign is_div = MDOp == 4'd3 || MDOp == 4'd4;
`ifdef MD_DIV0_FAST_EN
    assign div0_skip = is_div && D2 == 32'd0;
`else
    assign div0_skip = 1'b0;
`endif
    assign stall_D = md_in_D & (start | busy);
    assign md_rdata = MDOp == 4'd7 ? hi : MDOp == 4'd8 ? lo : 32'd0;
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            core_a      <= '0;
            core_b      <= '0;
            core_signed <= 1'b0;
            core_div    <= 1'b0;
            start       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_md && !div0_skip) begin
                        core_a      <= D1;
                        core_b      <= D2;
                        core_signed <= MDOp == 4'd1 || MDOp == 4'd3;
                        core_div    <= is_div;
                        cnt         <= is_div ? DIV_N : MULT_N;
                        start       <= 1'b1;
                        state       <= ISSUE;
                    end else if (req_E && MDOp == 4'd5) begin
                        hi <= D1;
                    end else if (req_E && MDOp == 4'd6) begin
                        lo <= D1;
                    end
                end
                ISSUE: begin
                    start <= 1'b0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                        if (!(core_div && core_b == 32'd0)) begin
                            hi <= core_hi;
                            lo <= core_lo;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
